// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, signed/unsigned per operation,
// valid/ready on both sides, two multiplier bits retired per cycle.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_num,
  input  logic [WIDTH-1:0]   b_num,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c_num,
  output logic               busy
);

  localparam int unsigned N_ITER = WIDTH / 2 + 1;
  localparam int unsigned EXT_W  = WIDTH + 2;
  localparam int unsigned MREG_W = EXT_W + 1;
  localparam int unsigned ACC_W  = 2 * WIDTH + 4;
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = $clog2(N_ITER);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_mult_seq: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [EXT_W-1:0]   a_ext;
  logic [MREG_W-1:0]  mreg;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   a_sx;
  logic [ACC_W-1:0]   pp;
  logic [ACC_W-1:0]   acc_sum;
  logic               accept;
  logic               last_iter;

  assign accept    = (state == IDLE) && in_valid && in_ready;
  assign last_iter = (cnt == CNT_W'(N_ITER - 1));

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_d = CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Booth digit selection; the extended multiplicand is treated as signed.
  always_comb begin
    a_sx = {{(ACC_W - EXT_W){a_ext[EXT_W-1]}}, a_ext};
    pp   = '0;
    case (mreg[2:0])
      3'b001, 3'b010: pp = a_sx;
      3'b011:         pp = a_sx << 1;
      3'b100:         pp = -(a_sx << 1);
      3'b101, 3'b110: pp = -a_sx;
      default:        pp = '0;
    endcase
    acc_sum = acc + (pp << {cnt, 1'b0});
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      c_num     <= '0;
    end else begin
      state     <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
      if (state == CALC && state_d == DONE) c_num <= acc_sum[PROD_W-1:0];
    end
  end

  // Datapath: operand capture on accept, one Booth iteration per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ext <= '0;
      mreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      a_ext <= is_signed ? {{2{a_num[WIDTH-1]}}, a_num} : {2'b00, a_num};
      mreg  <= is_signed ? {{2{b_num[WIDTH-1]}}, b_num, 1'b0} : {2'b00, b_num, 1'b0};
      acc   <= '0;
      cnt   <= '0;
    end else if (state == CALC) begin
      acc  <= acc_sum;
      mreg <= mreg >> 2;
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule
